// File: rtl/clock_set_ctrl.sv
// ============================================================================
//  Module   : clock_set_ctrl (with helper clock_set_ctrl_debounce)
//  Purpose  : HH:MM time-set controller with button conditioning, BCD shadow
//             time and digit blink mask. Optional macro: AUTO_REPEAT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_set_ctrl_debounce #(
   parameter int DEBOUNCE_CYC = 50000
) (
   input  logic clk0,
   input  logic rst_n,
   input  logic btn,
   output logic level
);
   localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

   logic            sync1_q, sync1_d;
   logic            sync2_q, sync2_d;
   logic            level_q, level_d;
   logic [DB_W-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d = btn;
      sync2_d = sync1_q;
      level_d = level_q;
      cnt_d   = '0;
      // Count consecutive cycles the synchronized input disagrees with the accepted level
      if (sync2_q != level_q) begin
         if (cnt_q == DB_LAST) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;
endmodule

module clock_set_ctrl #(
   parameter int DEBOUNCE_CYC = 50000,
   parameter int BLINK_CYC    = 25000000,
   parameter int REPEAT_DLY   = 50000000,
   parameter int REPEAT_CYC   = 10000000
) (
   input  logic       clk0,
   input  logic       rst_n,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic [1:0] cur_hour_t,
   input  logic [3:0] cur_hour_o,
   input  logic [2:0] cur_min_t,
   input  logic [3:0] cur_min_o,
   output logic       run_en,
   output logic       load,
   output logic [1:0] set_hour_t,
   output logic [3:0] set_hour_o,
   output logic [2:0] set_min_t,
   output logic [3:0] set_min_o,
   output logic [3:0] blink_mask,
   output logic [1:0] mode
);
   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_SET_HOUR = 2'b01,
      ST_SET_MIN  = 2'b10,
      ST_COMMIT   = 2'b11
   } state_t;

   localparam int BLINK_W = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYC - 1);

   logic mode_level, inc_level;
   logic mode_prev_q, mode_prev_d, mode_press_q, mode_press_d;
   logic inc_prev_q, inc_prev_d, inc_press_q, inc_press_d;
   logic inc_evt;

   state_t             state_q, state_d;
   logic [1:0]         hour_t_q, hour_t_d;
   logic [3:0]         hour_o_q, hour_o_d;
   logic [2:0]         min_t_q, min_t_d;
   logic [3:0]         min_o_q, min_o_d;
   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic               phase_q, phase_d;
   logic [3:0]         mask_q, mask_d;
   logic               run_en_q, run_en_d;
   logic               load_q, load_d;

   clock_set_ctrl_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_mode (
      .clk0  (clk0),
      .rst_n (rst_n),
      .btn   (btn_mode),
      .level (mode_level)
   );

   clock_set_ctrl_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_inc (
      .clk0  (clk0),
      .rst_n (rst_n),
      .btn   (btn_inc),
      .level (inc_level)
   );

   always_comb begin
      mode_prev_d  = mode_level;
      mode_press_d = mode_level & ~mode_prev_q;
      inc_prev_d   = inc_level;
      inc_press_d  = inc_level & ~inc_prev_q;
   end

`ifdef AUTO_REPEAT_EN
   localparam int REP_MAX = (REPEAT_DLY > REPEAT_CYC) ? REPEAT_DLY : REPEAT_CYC;
   localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX + 1) : 1;
   localparam logic [REP_W-1:0] REP_DLY_LAST = REP_W'(REPEAT_DLY - 1);
   localparam logic [REP_W-1:0] REP_CYC_LAST = REP_W'(REPEAT_CYC - 1);

   logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
   logic             rep_armed_q, rep_armed_d;
   logic             rep_fire;

   always_comb begin
      rep_cnt_d   = '0;
      rep_armed_d = 1'b0;
      rep_fire    = 1'b0;
      // Timer only runs while INC is held in an edit state with no mode change pending
      if (inc_level && !mode_press_q &&
          (state_q == ST_SET_HOUR || state_q == ST_SET_MIN)) begin
         rep_armed_d = rep_armed_q;
         if (!rep_armed_q) begin
            if (rep_cnt_q == REP_DLY_LAST) begin
               rep_fire    = 1'b1;
               rep_armed_d = 1'b1;
            end else begin
               rep_cnt_d = rep_cnt_q + 1'b1;
            end
         end else if (rep_cnt_q == REP_CYC_LAST) begin
            rep_fire = 1'b1;
         end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n) begin
         rep_cnt_q   <= '0;
         rep_armed_q <= 1'b0;
      end else begin
         rep_cnt_q   <= rep_cnt_d;
         rep_armed_q <= rep_armed_d;
      end
   end

   assign inc_evt = inc_press_q | rep_fire;
`else
   assign inc_evt = inc_press_q;
`endif

   function automatic logic [5:0] hour_inc(input logic [1:0] t, input logic [3:0] o);
      if (t == 2'd2 && o == 4'd3) return 6'd0;
      else if (o == 4'd9)         return {t + 2'd1, 4'd0};
      else                        return {t, o + 4'd1};
   endfunction

   function automatic logic [6:0] min_inc(input logic [2:0] t, input logic [3:0] o);
      if (o != 4'd9)       return {t, o + 4'd1};
      else if (t == 3'd5)  return 7'd0;
      else                 return {t + 3'd1, 4'd0};
   endfunction

   function automatic logic [5:0] hour_clamp(input logic [1:0] t, input logic [3:0] o);
      if (t > 2'd2 || o > 4'd9 || (t == 2'd2 && o > 4'd3)) return 6'd0;
      else                                                 return {t, o};
   endfunction

   function automatic logic [6:0] min_clamp(input logic [2:0] t, input logic [3:0] o);
      if (t > 3'd5 || o > 4'd9) return 7'd0;
      else                      return {t, o};
   endfunction

   always_comb begin
      state_d  = state_q;
      hour_t_d = hour_t_q;
      hour_o_d = hour_o_q;
      min_t_d  = min_t_q;
      min_o_d  = min_o_q;
      // MODE always takes priority over INC in the same cycle
      unique case (state_q)
         ST_RUN: begin
            if (mode_press_q) begin
               state_d              = ST_SET_HOUR;
               {hour_t_d, hour_o_d} = hour_clamp(cur_hour_t, cur_hour_o);
               {min_t_d, min_o_d}   = min_clamp(cur_min_t, cur_min_o);
            end
         end
         ST_SET_HOUR: begin
            if (mode_press_q)  state_d = ST_SET_MIN;
            else if (inc_evt)  {hour_t_d, hour_o_d} = hour_inc(hour_t_q, hour_o_q);
         end
         ST_SET_MIN: begin
            if (mode_press_q)  state_d = ST_COMMIT;
            else if (inc_evt)  {min_t_d, min_o_d} = min_inc(min_t_q, min_o_q);
         end
         ST_COMMIT: state_d = ST_RUN;
         default:   state_d = ST_RUN;
      endcase

      if (state_d != state_q) begin
         blink_cnt_d = '0;
         phase_d     = 1'b0;
      end else if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d = '0;
         phase_d     = ~phase_q;
      end else begin
         blink_cnt_d = blink_cnt_q + 1'b1;
         phase_d     = phase_q;
      end

      mask_d = 4'b0000;
      if (phase_d && state_d == ST_SET_HOUR) mask_d = 4'b1100;
      if (phase_d && state_d == ST_SET_MIN)  mask_d = 4'b0011;

      run_en_d = (state_d == ST_RUN);
      load_d   = (state_d == ST_COMMIT);
   end

   always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n) begin
         mode_prev_q  <= 1'b0;
         mode_press_q <= 1'b0;
         inc_prev_q   <= 1'b0;
         inc_press_q  <= 1'b0;
         state_q      <= ST_RUN;
         hour_t_q     <= '0;
         hour_o_q     <= '0;
         min_t_q      <= '0;
         min_o_q      <= '0;
         blink_cnt_q  <= '0;
         phase_q      <= 1'b0;
         mask_q       <= 4'b0000;
         run_en_q     <= 1'b1;
         load_q       <= 1'b0;
      end else begin
         mode_prev_q  <= mode_prev_d;
         mode_press_q <= mode_press_d;
         inc_prev_q   <= inc_prev_d;
         inc_press_q  <= inc_press_d;
         state_q      <= state_d;
         hour_t_q     <= hour_t_d;
         hour_o_q     <= hour_o_d;
         min_t_q      <= min_t_d;
         min_o_q      <= min_o_d;
         blink_cnt_q  <= blink_cnt_d;
         phase_q      <= phase_d;
         mask_q       <= mask_d;
         run_en_q     <= run_en_d;
         load_q       <= load_d;
      end
   end

   assign run_en     = run_en_q;
   assign load       = load_q;
   assign set_hour_t = hour_t_q;
   assign set_hour_o = hour_o_q;
   assign set_min_t  = min_t_q;
   assign set_min_o  = min_o_q;
   assign blink_mask = mask_q;
   assign mode       = state_q;
endmodule

`default_nettype wire
